// File: rtl/pll_seq_pkg.sv
// Shared state encodings, default timing and counter sizing for the PLL reset sequencer.
package pll_seq_pkg;

   localparam logic [2:0] PLLRST   = 3'd0;
   localparam logic [2:0] WAITLOCK = 3'd1;
   localparam logic [2:0] STABLE   = 3'd2;
   localparam logic [2:0] RELEASE  = 3'd3;
   localparam logic [2:0] RUN      = 3'd4;
   localparam logic [2:0] FAULT    = 3'd5;

   localparam int DEF_N_DOMAINS     = 2;
   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT  = 250000;
   localparam int DEF_STABLE_CYCLES = 2500;
   localparam int DEF_STAGGER       = 64;
   localparam int DEF_DEGLITCH      = 4;
   localparam int DEF_MAX_RETRIES   = 8;

   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer, clears to 0 on synchronous reset.
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL RST pin, waits for a stable lock with timeout/retry, then releases
// per-domain resets one at a time; lock loss while running restarts the sequence.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int N_DOMAINS     = DEF_N_DOMAINS,
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int STAGGER       = DEF_STAGGER,
   parameter int DEGLITCH      = DEF_DEGLITCH,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 pll_locked,
   output logic                 pll_rst,
   output logic [N_DOMAINS-1:0] rst_out,
   output logic                 ready,
   output logic                 fault,
   output logic [7:0]           lock_loss_count
);

   localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGGER);
   localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

   logic                 lk;
   logic [2:0]           state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [7:0]           retry, retry_n, retry_inc;
   logic [IW-1:0]        idx, idx_n;
   logic [7:0]           low, low_n;
   logic [N_DOMAINS-1:0] rst_n;
   logic                 ready_n, fault_n, pll_rst_n;
   logic [7:0]           llc_n;

   sync_2ff u_lock_sync (
      .clock (clock),
      .reset (reset),
      .d     (pll_locked),
      .q     (lk)
   );

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CW'(1);
      retry_n   = retry;
      retry_inc = retry + 8'd1;
      idx_n     = idx;
      low_n     = '0;
      rst_n     = rst_out;
      ready_n   = ready;
      fault_n   = fault;
      llc_n     = lock_loss_count;

      case (state)
         PLLRST: begin
            if (cnt == CW'(RST_CYCLES - 1)) state_n = WAITLOCK;
         end
         WAITLOCK: begin
            if (lk) begin
               state_n = STABLE;
               retry_n = '0;
            end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
               retry_n = retry_inc;
               if (retry_inc == 8'(MAX_RETRIES)) begin
                  state_n = FAULT;
                  fault_n = 1'b1;
               end else begin
                  state_n = PLLRST;
               end
            end
         end
         STABLE: begin
            // A low sample only restarts the stability window; the PLL is not re-pulsed.
            if (!lk) begin
               cnt_n = '0;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
               state_n  = RELEASE;
               idx_n    = '0;
               rst_n[0] = 1'b0;
            end
         end
         RELEASE, RUN: begin
            if (!lk) low_n = low + 8'd1;
            if (!lk && (low_n == 8'(DEGLITCH))) begin
               state_n = PLLRST;
               low_n   = '0;
               rst_n   = '1;
               ready_n = 1'b0;
               if (lock_loss_count != 8'hFF) llc_n = lock_loss_count + 8'd1;
            end else if (state == RELEASE) begin
               if (idx == IW'(N_DOMAINS - 1)) begin
                  state_n = RUN;
                  ready_n = 1'b1;
               end else if (cnt == CW'(STAGGER - 1)) begin
                  idx_n        = idx + IW'(1);
                  rst_n[idx_n] = 1'b0;
                  cnt_n        = '0;
               end
            end
         end
         FAULT: begin
            state_n = FAULT;
         end
         default: begin
            state_n = PLLRST;
            rst_n   = '1;
            ready_n = 1'b0;
         end
      endcase

      if (state_n != state) cnt_n = '0;
      pll_rst_n = (state_n == PLLRST) || (state_n == FAULT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= PLLRST;
         cnt             <= '0;
         retry           <= '0;
         idx             <= '0;
         low             <= '0;
         pll_rst         <= 1'b1;
         rst_out         <= '1;
         ready           <= 1'b0;
         fault           <= 1'b0;
         lock_loss_count <= '0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         retry           <= retry_n;
         idx             <= idx_n;
         low             <= low_n;
         pll_rst         <= pll_rst_n;
         rst_out         <= rst_n;
         ready           <= ready_n;
         fault           <= fault_n;
         lock_loss_count <= llc_n;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened timing; cycle numbers are
// negedges counted from the negedge where reset was released.
module tb_pll_reset_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       pll_locked;
   logic       pll_rst;
   logic [1:0] rst_out;
   logic       ready;
   logic       fault;
   logic [7:0] lock_loss_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clock = ~clock;

   pll_reset_sequencer #(
      .N_DOMAINS     (2),
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (100),
      .STABLE_CYCLES (16),
      .STAGGER       (8),
      .DEGLITCH      (3),
      .MAX_RETRIES   (3)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .pll_locked      (pll_locked),
      .pll_rst         (pll_rst),
      .rst_out         (rst_out),
      .ready           (ready),
      .fault           (fault),
      .lock_loss_count (lock_loss_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic at(input int t);
      while (cyc < t) tick(1);
   endtask

   task automatic wait_ready(input logic v, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (ready === v) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   initial begin
      int  rst_hi;
      bit  ok;
      bit  all_ok;
      int  exp_cnt;

      reset      = 1'b1;
      pll_locked = 1'b0;
      tick(3);
      chk("reset_pll_rst", pll_rst, 1);
      chk("reset_rst_out", rst_out, 2'b11);
      chk("reset_ready", ready, 0);
      chk("reset_fault", fault, 0);
      chk("reset_count", lock_loss_count, 0);

      // Test 1: nominal bring-up
      reset = 1'b0; cyc = 0;
      at(3);  chk("t1_pllrst_hi", pll_rst, 1);
      at(4);  chk("t1_pllrst_lo", pll_rst, 0);
      at(14); pll_locked = 1'b1;
      at(32); chk("t1_rst_before", rst_out, 2'b11);
      at(33); chk("t1_rst0_clear", rst_out, 2'b10);
      at(40); chk("t1_rst1_hold", rst_out, 2'b10);
      at(41); chk("t1_rst1_clear", rst_out, 2'b00);
              chk("t1_ready_late", ready, 0);
      at(42); chk("t1_ready", ready, 1);
              chk("t1_no_pulse", pll_rst, 0);

      // Test 4: short dip ignored, 3-cycle dip is a lock loss
      pll_locked = 1'b0;
      at(44); pll_locked = 1'b1;
      at(50); chk("t4_short_ready", ready, 1);
              chk("t4_short_count", lock_loss_count, 0);
              chk("t4_short_rst", rst_out, 2'b00);
      pll_locked = 1'b0;
      at(53); pll_locked = 1'b1;
      at(54); chk("t4_pre_loss", ready, 1);
      at(55); chk("t4_loss_ready", ready, 0);
              chk("t4_loss_rst", rst_out, 2'b11);
              chk("t4_loss_count", lock_loss_count, 1);
              chk("t4_loss_pllrst", pll_rst, 1);
      at(58); chk("t4_pulse_hi", pll_rst, 1);
      at(59); chk("t4_pulse_lo", pll_rst, 0);
      at(75); chk("t4_reseq_hold", rst_out, 2'b11);
      at(76); chk("t4_reseq_rst0", rst_out, 2'b10);
      at(85); chk("t4_reseq_ready", ready, 1);

      // Test 2: one-cycle glitch during STABLE restarts the window
      reset = 1'b1; pll_locked = 1'b0;
      tick(2);
      reset = 1'b0; cyc = 0;
      at(4);  pll_locked = 1'b1;
      rst_hi = 0;
      while (cyc < 10) begin tick(1); if (pll_rst) rst_hi++; end
      pll_locked = 1'b0;
      tick(1); if (pll_rst) rst_hi++;
      pll_locked = 1'b1;
      while (cyc < 28) begin tick(1); if (pll_rst) rst_hi++; end
      chk("t2_delayed_hold", rst_out, 2'b11);
      at(29); chk("t2_delayed_rst0", rst_out, 2'b10);
      chk("t2_no_pllrst", rst_hi, 0);

      // Test 5: reset during RELEASE
      at(30); reset = 1'b1;
      at(31); chk("t5_rst_out", rst_out, 2'b11);
              chk("t5_pll_rst", pll_rst, 1);
              chk("t5_ready", ready, 0);
              chk("t5_count", lock_loss_count, 0);

      // Test 3: lock never arrives -> retries then sticky fault
      reset = 1'b0; pll_locked = 1'b0; cyc = 0;
      at(103); chk("t3_wait1", pll_rst, 0);
      at(104); chk("t3_pulse2", pll_rst, 1);
      at(107); chk("t3_pulse2_hi", pll_rst, 1);
      at(108); chk("t3_pulse2_lo", pll_rst, 0);
      at(208); chk("t3_pulse3", pll_rst, 1);
      at(212); chk("t3_pulse3_lo", pll_rst, 0);
      at(311); chk("t3_nofault", fault, 0);
      at(312); chk("t3_fault", fault, 1);
               chk("t3_fault_pllrst", pll_rst, 1);
               chk("t3_fault_rst", rst_out, 2'b11);
      pll_locked = 1'b1;
      at(360); chk("t3_sticky", fault, 1);
               chk("t3_sticky_ready", ready, 0);
      reset = 1'b1;
      tick(1); chk("t3_reset_clears", fault, 0);

      // Test 6: repeated lock losses saturate the counter
      reset = 1'b0; cyc = 0;
      all_ok = 1'b1;
      for (int i = 0; i < 300; i++) begin
         wait_ready(1'b1, 200, ok);
         if (!ok) all_ok = 1'b0;
         pll_locked = 1'b0;
         tick(3);
         pll_locked = 1'b1;
         wait_ready(1'b0, 10, ok);
         if (!ok) all_ok = 1'b0;
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         if (i == 0 || i == 9 || i == 254 || i == 255 || i == 299)
            chk($sformatf("t6_count_%0d", i), lock_loss_count, exp_cnt);
      end
      chk("t6_all_cycles", all_ok, 1);
      wait_ready(1'b1, 200, ok);
      chk("t6_final_recover", ok, 1);
      chk("t6_final_rst", rst_out, 2'b00);
      chk("t6_final_count", lock_loss_count, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
